phase_sequencer: RTL and testbench

Instruction phase sequencer for the multi-cycle CPU core. Drives the fetch, decode, operand-select and ALU/load strobes that fetch, decode, selector, alu, alu_result_selector and the register files consume. Skips the select/execute slots an instruction does not use, based on its decoded micro-op count. Supports external stall and halt, and counts retired instructions.

---
 rtl/phase_sequencer.sv | 111 +++++++++++
 tb/tb_phase_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer for the multi-cycle core. Walks each instruction through
// fetch, decode, up to three select/execute pairs and an EIP-advance slot, skipping the
// pairs an instruction does not use. Supports stall, halt-after-instruction and counts
// retired instructions.
module phase_sequencer #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned MAX_OPS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       num_of_ope,
    input  logic             stall,
    input  logic             halt,
    output logic             fetch_en,
    output logic             decode_en,
    output logic [2:0]       sel_en,
    output logic [2:0]       exe_en,
    output logic             eip_adv,
    output logic [1:0]       op_count,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [1:0] MaxOps = 2'(MAX_OPS);

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StSel1,
        StExe1,
        StSel2,
        StExe2,
        StSel3,
        StExe3,
        StAdv,
        StHalt
    } state_e;

    state_e           state_q;
    logic [1:0]       op_count_q;
    logic [CNT_W-1:0] retired_q;
    logic [1:0]       ope_clamped;
    logic             advance;

    // Counts above the supported maximum saturate rather than wrap.
    assign ope_clamped = (num_of_ope > 4'(MaxOps)) ? MaxOps : num_of_ope[1:0];

    // IDLE and HALT ignore stall; every other state holds while stalled.
    assign advance = !stall || (state_q == StIdle) || (state_q == StHalt);

    // State, latched micro-op count and retire counter; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            op_count_q <= 2'd0;
            retired_q  <= '0;
        end else if (advance) begin
            unique case (state_q)
                StIdle:   state_q <= StFetch;
                StFetch:  state_q <= StDecode;
                StDecode: begin
                    op_count_q <= ope_clamped;
                    state_q    <= (ope_clamped == 2'd0) ? StAdv : StSel1;
                end
                StSel1:   state_q <= StExe1;
                StExe1:   state_q <= (op_count_q > 2'd1) ? StSel2 : StAdv;
                StSel2:   state_q <= StExe2;
                StExe2:   state_q <= (op_count_q > 2'd2) ? StSel3 : StAdv;
                StSel3:   state_q <= StExe3;
                StExe3:   state_q <= StAdv;
                StAdv: begin
                    retired_q <= retired_q + 1'b1;
                    state_q   <= halt ? StHalt : StFetch;
                end
                StHalt:   state_q <= StHalt;
                default:  state_q <= StIdle;
            endcase
        end
    end

    // Moore strobe decode; a stalled cycle suppresses every strobe.
    always_comb begin
        fetch_en  = 1'b0;
        decode_en = 1'b0;
        sel_en    = 3'b000;
        exe_en    = 3'b000;
        eip_adv   = 1'b0;
        if (!stall) begin
            unique case (state_q)
                StFetch:  fetch_en  = 1'b1;
                StDecode: decode_en = 1'b1;
                StSel1:   sel_en    = 3'b001;
                StExe1:   exe_en    = 3'b001;
                StSel2:   sel_en    = 3'b010;
                StExe2:   exe_en    = 3'b010;
                StSel3:   sel_en    = 3'b100;
                StExe3:   exe_en    = 3'b100;
                StAdv:    eip_adv   = 1'b1;
                default:  ;
            endcase
        end
    end

    assign op_count = op_count_q;
    assign retired  = retired_q;
    assign busy     = (state_q != StIdle) && (state_q != StHalt);
    assign halted   = (state_q == StHalt);

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed instruction scenarios with literal expectations,
// then randomized stall/halt/reset/op-count traffic checked every cycle against a
// queue-based phase schedule model.
module tb_phase_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        halt;
    logic [3:0]  num_of_ope;

    logic        fetch_en, decode_en, eip_adv, busy, halted;
    logic [2:0]  sel_en, exe_en;
    logic [1:0]  op_count;
    logic [15:0] retired;

    // Narrow-counter copy so retire-count wraparound is reachable quickly.
    logic        w_fetch_en, w_decode_en, w_eip_adv, w_busy, w_halted;
    logic [2:0]  w_sel_en, w_exe_en;
    logic [1:0]  w_op_count;
    logic [2:0]  w_retired;

    phase_sequencer #(.CNT_W(16), .MAX_OPS(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .num_of_ope (num_of_ope),
        .stall      (stall),
        .halt       (halt),
        .fetch_en   (fetch_en),
        .decode_en  (decode_en),
        .sel_en     (sel_en),
        .exe_en     (exe_en),
        .eip_adv    (eip_adv),
        .op_count   (op_count),
        .busy       (busy),
        .halted     (halted),
        .retired    (retired)
    );

    phase_sequencer #(.CNT_W(3), .MAX_OPS(3)) dut_w (
        .clk        (clk),
        .reset      (reset),
        .num_of_ope (num_of_ope),
        .stall      (stall),
        .halt       (halt),
        .fetch_en   (w_fetch_en),
        .decode_en  (w_decode_en),
        .sel_en     (w_sel_en),
        .exe_en     (w_exe_en),
        .eip_adv    (w_eip_adv),
        .op_count   (w_op_count),
        .busy       (w_busy),
        .halted     (w_halted),
        .retired    (w_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Phase codes: sel n is 10+n, exe n is 20+n.
    localparam int PhIdle = 0, PhFetch = 1, PhDecode = 2, PhAdv = 3, PhHalt = 4;

    int          m_phase = PhIdle;
    int          m_ops   = 0;
    logic [15:0] m_ret   = '0;
    int          m_q[$];

    // Per-cycle trace of DUT observations for the directed literal checks.
    // Strobe code: {fetch, decode, sel[2:0], exe[2:0], eip}.
    int unsigned tr_code[64];
    int unsigned tr_ops[64];
    int unsigned tr_ret[64];
    int unsigned tr_busy[64];
    int unsigned tr_halt[64];
    int          tidx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [28:0] expect_vec(input logic s);
        logic       f, d, e, b, hd;
        logic [2:0] se, ex;
        f  = (m_phase == PhFetch) && !s;
        d  = (m_phase == PhDecode) && !s;
        e  = (m_phase == PhAdv) && !s;
        se = 3'b000;
        ex = 3'b000;
        if (!s && m_phase >= 11 && m_phase <= 13) se[m_phase-11] = 1'b1;
        if (!s && m_phase >= 21 && m_phase <= 23) ex[m_phase-21] = 1'b1;
        b  = (m_phase != PhIdle) && (m_phase != PhHalt);
        hd = (m_phase == PhHalt);
        return {f, d, se, ex, e, 2'(m_ops), b, hd, m_ret};
    endfunction

    task automatic model_step(input logic r, input logic s, input logic h, input logic [3:0] n);
        if (!r) begin
            m_phase = PhIdle;
            m_ops   = 0;
            m_ret   = '0;
            m_q.delete();
        end else if (m_phase == PhIdle) begin
            m_phase = PhFetch;
        end else if (m_phase == PhHalt || s) begin
            // held
        end else if (m_phase == PhFetch) begin
            m_phase = PhDecode;
        end else if (m_phase == PhDecode) begin
            m_ops = (n > 4'd3) ? 3 : int'(n);
            m_q.delete();
            for (int i = 1; i <= m_ops; i++) begin
                m_q.push_back(10 + i);
                m_q.push_back(20 + i);
            end
            m_q.push_back(PhAdv);
            m_phase = m_q.pop_front();
        end else if (m_phase == PhAdv) begin
            m_ret   = m_ret + 16'd1;
            m_phase = h ? PhHalt : PhFetch;
        end else begin
            m_phase = m_q.pop_front();
        end
    endtask

    task automatic cycle(input logic r, input logic s, input logic h, input logic [3:0] n);
        logic [28:0] act;
        @(posedge clk);
        #1;
        reset      = r;
        stall      = s;
        halt       = h;
        num_of_ope = n;
        #3;
        act = {fetch_en, decode_en, sel_en, exe_en, eip_adv, op_count, busy, halted, retired};
        check("cycle_outputs", 32'(act), 32'(expect_vec(s)));
        check("narrow_retired", 32'(w_retired), 32'(m_ret[2:0]));
        if (tidx < 64) begin
            tr_code[tidx] = {fetch_en, decode_en, sel_en, exe_en, eip_adv};
            tr_ops[tidx]  = op_count;
            tr_ret[tidx]  = retired;
            tr_busy[tidx] = busy;
            tr_halt[tidx] = halted;
        end
        tidx++;
        model_step(r, s, h, n);
    endtask

    task automatic do_reset();
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 4'd0);
        tidx = 0;
    endtask

    initial begin
        reset      = 1'b0;
        stall      = 1'b0;
        halt       = 1'b0;
        num_of_ope = 4'd0;

        // One single-op instruction after reset.
        do_reset();
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, 4'd1);
        check("t1_idle_code", tr_code[0], 32'h000);
        check("t1_idle_busy", tr_busy[0], 32'd0);
        check("t1_idle_ret", tr_ret[0], 32'd0);
        check("t1_fetch", tr_code[1], 32'h100);
        check("t1_decode", tr_code[2], 32'h080);
        check("t1_sel1", tr_code[3], 32'h010);
        check("t1_exe1", tr_code[4], 32'h002);
        check("t1_eip", tr_code[5], 32'h001);
        check("t1_refetch", tr_code[6], 32'h100);
        check("t1_ops", tr_ops[4], 32'd1);
        check("t1_ret_before", tr_ret[5], 32'd0);
        check("t1_ret_after", tr_ret[6], 32'd1);

        // Three ops then two ops, back to back.
        do_reset();
        for (int i = 0; i < 18; i++) cycle(1'b1, 1'b0, 1'b0, (i < 5) ? 4'd3 : 4'd2);
        check("t2_s1", tr_code[3], 32'h010);
        check("t2_e1", tr_code[4], 32'h002);
        check("t2_s2", tr_code[5], 32'h020);
        check("t2_e2", tr_code[6], 32'h004);
        check("t2_s3", tr_code[7], 32'h040);
        check("t2_e3", tr_code[8], 32'h008);
        check("t2_eip_a", tr_code[9], 32'h001);
        check("t2_fetch_b", tr_code[10], 32'h100);
        check("t2_b_s2", tr_code[14], 32'h020);
        check("t2_b_e2", tr_code[15], 32'h004);
        check("t2_eip_b", tr_code[16], 32'h001);
        check("t2_ret", tr_ret[17], 32'd2);

        // NOP followed by a clamped count of 7.
        do_reset();
        for (int i = 0; i < 13; i++) cycle(1'b1, 1'b0, 1'b0, (i < 4) ? 4'd0 : 4'd7);
        check("t3_nop_decode", tr_code[2], 32'h080);
        check("t3_nop_eip", tr_code[3], 32'h001);
        check("t3_nop_ops", tr_ops[3], 32'd0);
        check("t3_fetch", tr_code[4], 32'h100);
        check("t3_s1", tr_code[6], 32'h010);
        check("t3_ops_clamp", tr_ops[6], 32'd3);
        check("t3_e3", tr_code[11], 32'h008);
        check("t3_eip", tr_code[12], 32'h001);

        // Four-cycle stall in SEL2.
        do_reset();
        for (int i = 0; i < 13; i++) cycle(1'b1, (i >= 5 && i <= 8), 1'b0, 4'd2);
        check("t4_e1", tr_code[4], 32'h002);
        check("t4_stall_first", tr_code[5], 32'h000);
        check("t4_stall_last", tr_code[8], 32'h000);
        check("t4_stall_busy", tr_busy[7], 32'd1);
        check("t4_s2", tr_code[9], 32'h020);
        check("t4_e2", tr_code[10], 32'h004);
        check("t4_eip", tr_code[11], 32'h001);
        check("t4_ret_before", tr_ret[11], 32'd0);
        check("t4_ret_after", tr_ret[12], 32'd1);

        // Halt pulse in EXE1 ignored, halt in ADV honoured.
        do_reset();
        for (int i = 0; i < 13; i++) cycle(1'b1, 1'b0, (i == 4 || i == 7), 4'd2);
        check("t5_s2_after_pulse", tr_code[5], 32'h020);
        check("t5_eip", tr_code[7], 32'h001);
        check("t5_not_halted_yet", tr_halt[7], 32'd0);
        check("t5_halted", tr_halt[8], 32'd1);
        check("t5_busy", tr_busy[8], 32'd0);
        check("t5_ret", tr_ret[8], 32'd1);
        check("t5_quiet_a", tr_code[9], 32'h000);
        check("t5_quiet_b", tr_code[12], 32'h000);

        // Reset during a stalled EXE2, then restart.
        do_reset();
        for (int i = 0; i < 13; i++) cycle((i != 9), (i == 9), 1'b0, (i < 4) ? 4'd0 : 4'd2);
        check("t6_stalled_e2", tr_code[9], 32'h000);
        check("t6_ops_pre", tr_ops[9], 32'd2);
        check("t6_ret_pre", tr_ret[9], 32'd1);
        check("t6_code_post", tr_code[10], 32'h000);
        check("t6_ret_post", tr_ret[10], 32'd0);
        check("t6_ops_post", tr_ops[10], 32'd0);
        check("t6_busy_post", tr_busy[10], 32'd0);
        check("t6_refetch", tr_code[11], 32'h100);
        check("t6_redecode", tr_code[12], 32'h080);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic r, s, h;
            r = !(($urandom % 150) == 0 || (m_phase == PhHalt && ($urandom % 6) == 0));
            s = ($urandom % 4) == 0;
            h = ($urandom % 12) == 0;
            cycle(r, s, h, 4'($urandom % 16));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
